deci32_accum: RTL and testbench
===============================

// Module: deci32_accum
// PURPOSE
//  Sequencer/accumulator that reads the 160-tap DSD decimation coefficient ROM (10 phases x 16 addr,
//  sign-selected by 1-bit x/y inputs). Shifts in stereo 1-bit DSD, snapshots 160-bit history every
//  DECIM bits, sweeps ROM addr 0..15, sums 20 signed taps/cycle, emits saturated stereo PCM.
//  Sits between the DSD input deserializer and the PCM output/FIFO stage.
// PARAMETERS
//  DECIM    32  input bits per output sample; legal 2..255
//  ACC_W    40  accumulator width (signed)
//  SHIFT    7   arithmetic right shift applied to acc before saturation
//  OUT_W    24  PCM output width (signed)
// PORTS
//  clk            in   1        system clock
//  rst            in   1        asynchronous, active-high reset
//  dsd_l, dsd_r   in   1        DSD bits (1 = +coef, 0 = -coef)
//  dsd_valid      in   1        one-cycle strobe: accept dsd_l/dsd_r this edge
//  rom_addr       out  4        ROM address
//  rom_x, rom_y   out  10       ROM sign selects, bit k -> phase k, left/right
//  rom_tap_left   in   320      ROM left taps, phase k at [32k+31:32k], signed
//  rom_tap_right  in   320      ROM right taps, same packing
//  pcm_l, pcm_r   out  OUT_W    PCM sample, signed, held until next update
//  pcm_valid      out  1        one-cycle pulse, new pcm_l/pcm_r
//  busy           out  1        1 while state != IDLE
//  overrun        out  1        sticky: block trigger arrived while busy
//  overrun_clr    in   1        synchronous clear of overrun
// BEHAVIOUR
//  - Reset: hist_l/r and snap_l/r = {80{2'b10}} (silence), bit_cnt=0, acc_l/r=0, state=IDLE,
//    rom_addr=0, rom_x=rom_y=0, pcm_l=pcm_r=0, pcm_valid=0, overrun=0. Reset mid-ACCUM aborts, no output.
//  - Shift: on dsd_valid, hist <= {hist[158:0], dsd}; hist[0] = newest bit. Shifting continues in all
//    states; compute uses snapshot only.
//  - bit_cnt counts accepted bits 0..DECIM-1, wraps. Trigger = dsd_valid && bit_cnt==DECIM-1.
//  - FSM IDLE -> ACCUM -> OUTP -> IDLE.
//    IDLE: on trigger: snap <= shifted hist (incl. this bit), acc<=0, addr<=0, -> ACCUM.
//    ACCUM (16 cycles): rom_x[k]=snap_l[10*addr+k], rom_y[k]=snap_r[10*addr+k]; ROM is combinational;
//      each edge acc <= acc + sext(sum of 10 taps); addr++; on addr==15 -> OUTP.
//    OUTP: pcm <= sat_OUT_W(acc >>> SHIFT); pcm_valid=1 next cycle; addr<=0, x/y<=0; -> IDLE.
//  - Latency: pcm_valid high in cycle 17 after the trigger edge (trigger edge = edge 0). Busy 17 cycles.
//  - Arithmetic: taps sign-extended to ACC_W; 10-way add + acc in one cycle, no intermediate truncation.
//    Saturation: clamp to [-2^(OUT_W-1), 2^(OUT_W-1)-1].
//  - Trigger while busy: block dropped, overrun<=1, in-flight compute unaffected, bit_cnt still wraps.
//  - overrun_clr and new overrun same cycle: set wins.
//  - Left and right channels compute in lockstep; one pcm_valid for both.
// TESTING
//  1 Reset, no input -> all outputs at reset values, busy=0, no pcm_valid for 1000 cycles.
//  2 320 bits of 1 on L, 0 on R, dsd_valid every 4 cycles -> from 5th pcm_valid on,
//    pcm_l = sat((+sum of 160 coefs)>>>7), pcm_r = sat((-sum)>>>7), bit-exact vs bench model.
//  3 Trigger edge T -> busy 1 on T+1..T+17, pcm_valid only in cycle T+17, rom_addr steps 0..15 on T+1..T+16.
//  4 SHIFT=0, OUT_W=24, all-ones input -> pcm_l=24'h7FFFFF; all-zeros -> 24'h800000.
//  5 DECIM=8, dsd_valid every cycle -> overrun=1 at 2nd trigger, dropped block gives no pcm_valid;
//    overrun_clr pulse -> 0.
//  6 Assert rst at ACCUM addr=7 -> outputs to reset values immediately, no pcm_valid, next block normal.

Source files
------------

// File: rtl/deci32_accum_if.sv
// Bus between the DSD decimation accumulator, its coefficient ROM and the PCM consumer.
interface deci32_accum_if #(
  parameter int unsigned OUT_W = 24
) ();
  logic                    dsd_l;
  logic                    dsd_r;
  logic                    dsd_valid;
  logic [3:0]              rom_addr;
  logic [9:0]              rom_x;
  logic [9:0]              rom_y;
  logic [319:0]            rom_tap_left;
  logic [319:0]            rom_tap_right;
  logic signed [OUT_W-1:0] pcm_l;
  logic signed [OUT_W-1:0] pcm_r;
  logic                    pcm_valid;
  logic                    busy;
  logic                    overrun;
  logic                    overrun_clr;

  // Environment side: supplies DSD bits and ROM taps, consumes PCM.
  modport master (
    output dsd_l, dsd_r, dsd_valid, rom_tap_left, rom_tap_right, overrun_clr,
    input  rom_addr, rom_x, rom_y, pcm_l, pcm_r, pcm_valid, busy, overrun
  );

  // Accumulator side.
  modport slave (
    input  dsd_l, dsd_r, dsd_valid, rom_tap_left, rom_tap_right, overrun_clr,
    output rom_addr, rom_x, rom_y, pcm_l, pcm_r, pcm_valid, busy, overrun
  );
endinterface

// File: rtl/deci32_accum.sv
// Stereo DSD-to-PCM decimation accumulator. Shifts 1-bit DSD into a 160-bit history, snapshots
// it every DECIM bits, sweeps the 16-entry coefficient ROM (10 phases per entry) and emits a
// saturated, shifted PCM sample per channel.
module deci32_accum #(
  parameter int unsigned DECIM = 32,
  parameter int unsigned ACC_W = 40,
  parameter int unsigned SHIFT = 7,
  parameter int unsigned OUT_W = 24
) (
  input logic            clk,
  input logic            rst,
  deci32_accum_if.slave  bus
);

  localparam int unsigned NTAP  = 160;
  localparam int unsigned NPH   = 10;
  localparam int unsigned TAP_W = 32;

  localparam logic [NTAP-1:0] SILENCE  = {80{2'b10}};
  localparam logic [7:0]      LAST_BIT = 8'(DECIM - 1);

  localparam logic signed [ACC_W-1:0] PCM_MAX = {{(ACC_W-OUT_W+1){1'b0}}, {(OUT_W-1){1'b1}}};
  localparam logic signed [ACC_W-1:0] PCM_MIN = {{(ACC_W-OUT_W+1){1'b1}}, {(OUT_W-1){1'b0}}};

  typedef enum logic [1:0] {StIdle, StAccum, StOutp} state_e;

  state_e                  state_q, state_d;
  logic [NTAP-1:0]         hist_l_q, hist_l_d, hist_r_q, hist_r_d;
  logic [NTAP-1:0]         snap_l_q, snap_l_d, snap_r_q, snap_r_d;
  logic [7:0]              bit_cnt_q, bit_cnt_d;
  logic signed [ACC_W-1:0] acc_l_q, acc_l_d, acc_r_q, acc_r_d;
  logic [3:0]              addr_q, addr_d;
  logic signed [OUT_W-1:0] pcm_l_q, pcm_l_d, pcm_r_q, pcm_r_d;
  logic                    pcm_valid_q, pcm_valid_d;
  logic                    overrun_q, overrun_d;

  logic                    trigger;
  logic signed [ACC_W-1:0] tap_sum_l, tap_sum_r;
  logic signed [ACC_W-1:0] acc_l_sum, acc_r_sum;
  logic [7:0]              base;
  logic [NPH-1:0]          rom_x, rom_y;

  // The oldest history bit is shifted out and never reaches a snapshot.
  logic unused_hist;
  assign unused_hist = hist_l_q[NTAP-1] ^ hist_r_q[NTAP-1];

  function automatic logic signed [OUT_W-1:0] saturate(input logic signed [ACC_W-1:0] v);
    logic signed [ACC_W-1:0] s;
    s = v >>> SHIFT;
    if (s > PCM_MAX) return PCM_MAX[OUT_W-1:0];
    if (s < PCM_MIN) return PCM_MIN[OUT_W-1:0];
    return s[OUT_W-1:0];
  endfunction

  assign trigger = bus.dsd_valid && (bit_cnt_q == LAST_BIT);

  // History shift, bit counter and sticky overrun flag run regardless of FSM state.
  always_comb begin
    hist_l_d  = hist_l_q;
    hist_r_d  = hist_r_q;
    bit_cnt_d = bit_cnt_q;
    overrun_d = overrun_q;
    if (bus.dsd_valid) begin
      hist_l_d  = {hist_l_q[NTAP-2:0], bus.dsd_l};
      hist_r_d  = {hist_r_q[NTAP-2:0], bus.dsd_r};
      bit_cnt_d = trigger ? 8'd0 : bit_cnt_q + 8'd1;
    end
    if (bus.overrun_clr) overrun_d = 1'b0;
    // Set wins over a same-cycle clear.
    if (trigger && (state_q != StIdle)) overrun_d = 1'b1;
  end

  // Sign-extend and add the ten phase taps of the current ROM word, per channel.
  always_comb begin
    tap_sum_l = '0;
    tap_sum_r = '0;
    for (int k = 0; k < NPH; k++) begin
      tap_sum_l = tap_sum_l + ACC_W'($signed(bus.rom_tap_left[TAP_W*k +: TAP_W]));
      tap_sum_r = tap_sum_r + ACC_W'($signed(bus.rom_tap_right[TAP_W*k +: TAP_W]));
    end
    acc_l_sum = acc_l_q + tap_sum_l;
    acc_r_sum = acc_r_q + tap_sum_r;
  end

  // ROM sign selects: the ten snapshot bits belonging to the current address, zero otherwise.
  always_comb begin
    base  = 8'(addr_q) * 8'd10;
    rom_x = '0;
    rom_y = '0;
    if (state_q == StAccum) begin
      rom_x = snap_l_q[base +: NPH];
      rom_y = snap_r_q[base +: NPH];
    end
  end

  // Sequencer: snapshot on trigger, 16 accumulate cycles, one output cycle.
  always_comb begin
    state_d     = state_q;
    snap_l_d    = snap_l_q;
    snap_r_d    = snap_r_q;
    acc_l_d     = acc_l_q;
    acc_r_d     = acc_r_q;
    addr_d      = addr_q;
    pcm_l_d     = pcm_l_q;
    pcm_r_d     = pcm_r_q;
    pcm_valid_d = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (trigger) begin
          snap_l_d = hist_l_d;
          snap_r_d = hist_r_d;
          acc_l_d  = '0;
          acc_r_d  = '0;
          addr_d   = 4'd0;
          state_d  = StAccum;
        end
      end
      StAccum: begin
        acc_l_d = acc_l_sum;
        acc_r_d = acc_r_sum;
        addr_d  = addr_q + 4'd1;
        if (addr_q == 4'd15) begin
          // Register the final sum on the last accumulate edge so pcm_valid is seen during
          // the single output cycle, 17 cycles after the trigger edge.
          pcm_l_d     = saturate(acc_l_sum);
          pcm_r_d     = saturate(acc_r_sum);
          pcm_valid_d = 1'b1;
          state_d     = StOutp;
        end
      end
      StOutp: begin
        addr_d  = 4'd0;
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  // State registers; reset aborts any block in flight.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= StIdle;
      hist_l_q    <= SILENCE;
      hist_r_q    <= SILENCE;
      snap_l_q    <= SILENCE;
      snap_r_q    <= SILENCE;
      bit_cnt_q   <= 8'd0;
      acc_l_q     <= '0;
      acc_r_q     <= '0;
      addr_q      <= 4'd0;
      pcm_l_q     <= '0;
      pcm_r_q     <= '0;
      pcm_valid_q <= 1'b0;
      overrun_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      hist_l_q    <= hist_l_d;
      hist_r_q    <= hist_r_d;
      snap_l_q    <= snap_l_d;
      snap_r_q    <= snap_r_d;
      bit_cnt_q   <= bit_cnt_d;
      acc_l_q     <= acc_l_d;
      acc_r_q     <= acc_r_d;
      addr_q      <= addr_d;
      pcm_l_q     <= pcm_l_d;
      pcm_r_q     <= pcm_r_d;
      pcm_valid_q <= pcm_valid_d;
      overrun_q   <= overrun_d;
    end
  end

  assign bus.rom_addr  = addr_q;
  assign bus.rom_x     = rom_x;
  assign bus.rom_y     = rom_y;
  assign bus.pcm_l     = pcm_l_q;
  assign bus.pcm_r     = pcm_r_q;
  assign bus.pcm_valid = pcm_valid_q;
  assign bus.busy      = (state_q != StIdle);
  assign bus.overrun   = overrun_q;

endmodule

// File: tb/tb_deci32_accum.sv
// Bench for deci32_accum: DUT A (DECIM=32, SHIFT=7) against a bit-level reference model,
// DUT B (DECIM=8, SHIFT=0) for saturation and overrun behaviour.
`timescale 1ns/1ps
module tb_deci32_accum;

  logic clk = 1'b0;
  logic rst_a;
  logic rst_b;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  deci32_accum_if #(.OUT_W(24)) bus_a ();
  deci32_accum_if #(.OUT_W(24)) bus_b ();

  deci32_accum #(.DECIM(32), .ACC_W(40), .SHIFT(7), .OUT_W(24)) dut_a (
    .clk (clk),
    .rst (rst_a),
    .bus (bus_a)
  );

  deci32_accum #(.DECIM(8), .ACC_W(40), .SHIFT(0), .OUT_W(24)) dut_b (
    .clk (clk),
    .rst (rst_b),
    .bus (bus_b)
  );

  // Coefficient j = 10*addr + phase; sum over all 160 is 12,880,480.
  function automatic int coef(input int j);
    return 1000 * (j + 1) + 3;
  endfunction

  function automatic logic [319:0] rom_taps(input logic [3:0] addr, input logic [9:0] sel);
    logic [319:0] t;
    int c;
    t = '0;
    for (int k = 0; k < 10; k++) begin
      c = coef(10 * int'(addr) + k);
      t[32*k +: 32] = sel[k] ? c : -c;
    end
    return t;
  endfunction

  assign bus_a.rom_tap_left  = rom_taps(bus_a.rom_addr, bus_a.rom_x);
  assign bus_a.rom_tap_right = rom_taps(bus_a.rom_addr, bus_a.rom_y);
  assign bus_b.rom_tap_left  = rom_taps(bus_b.rom_addr, bus_b.rom_x);
  assign bus_b.rom_tap_right = rom_taps(bus_b.rom_addr, bus_b.rom_y);

  function automatic logic signed [23:0] model_pcm(input logic [159:0] h, input int shift);
    longint s;
    s = 0;
    for (int j = 0; j < 160; j++) s += h[j] ? longint'(coef(j)) : -longint'(coef(j));
    s = s >>> shift;
    if (s > longint'(8388607)) s = 8388607;
    else if (s < -longint'(8388608)) s = -8388608;
    return 24'(s);
  endfunction

  // Reference model state for DUT A.
  logic [159:0]      m_hist_l, m_hist_r, m_snap_l, m_snap_r;
  int                m_cnt;
  logic signed [23:0] exp_l[$];
  logic signed [23:0] exp_r[$];

  // Captured outputs.
  logic signed [23:0] got_l[$];
  logic signed [23:0] got_r[$];
  int                 pv_a = 0;
  int                 pv_b = 0;
  logic signed [23:0] last_b_l = '0;
  logic signed [23:0] last_b_r = '0;

  always @(negedge clk) begin
    if (bus_a.pcm_valid === 1'b1) begin
      got_l.push_back(bus_a.pcm_l);
      got_r.push_back(bus_a.pcm_r);
      pv_a <= pv_a + 1;
    end
    if (bus_b.pcm_valid === 1'b1) begin
      last_b_l <= bus_b.pcm_l;
      last_b_r <= bus_b.pcm_r;
      pv_b     <= pv_b + 1;
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: time limit reached, checks=%0d errors=%0d", checks, errors);
    $fatal(1, "watchdog");
  end

  task automatic model_reset_a();
    m_hist_l = {80{2'b10}};
    m_hist_r = {80{2'b10}};
    m_snap_l = {80{2'b10}};
    m_snap_r = {80{2'b10}};
    m_cnt    = 0;
  endtask

  task automatic reset_a();
    rst_a = 1'b1;
    bus_a.dsd_l = 1'b0; bus_a.dsd_r = 1'b0; bus_a.dsd_valid = 1'b0; bus_a.overrun_clr = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk) rst_a = 1'b0;
    model_reset_a();
  endtask

  task automatic reset_b();
    rst_b = 1'b1;
    bus_b.dsd_l = 1'b0; bus_b.dsd_r = 1'b0; bus_b.dsd_valid = 1'b0; bus_b.overrun_clr = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk) rst_b = 1'b0;
  endtask

  task automatic drive_a(input logic l, input logic r);
    bus_a.dsd_l = l; bus_a.dsd_r = r; bus_a.dsd_valid = 1'b1;
    @(posedge clk);
    m_hist_l = {m_hist_l[158:0], l};
    m_hist_r = {m_hist_r[158:0], r};
    if (m_cnt == 31) begin
      m_cnt    = 0;
      m_snap_l = m_hist_l;
      m_snap_r = m_hist_r;
      exp_l.push_back(model_pcm(m_hist_l, 7));
      exp_r.push_back(model_pcm(m_hist_r, 7));
    end else begin
      m_cnt++;
    end
    #1 bus_a.dsd_valid = 1'b0;
  endtask

  task automatic drive_b(input logic l, input logic r, input logic clr);
    bus_b.dsd_l = l; bus_b.dsd_r = r; bus_b.dsd_valid = 1'b1; bus_b.overrun_clr = clr;
    @(posedge clk);
    #1 bus_b.dsd_valid = 1'b0; bus_b.overrun_clr = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    int bad;
    reset_a();
    reset_b();
    checks++; if (bus_a.busy !== 1'b0) begin errors++; $display("FAIL reset busy: got %b want 0", bus_a.busy); end
    checks++; if (bus_a.pcm_valid !== 1'b0) begin errors++; $display("FAIL reset pcm_valid: got %b want 0", bus_a.pcm_valid); end
    checks++; if (bus_a.rom_addr !== 4'd0) begin errors++; $display("FAIL reset rom_addr: got %0d want 0", bus_a.rom_addr); end
    checks++; if (bus_a.rom_x !== 10'd0 || bus_a.rom_y !== 10'd0) begin errors++; $display("FAIL reset rom_xy: got %h/%h want 0/0", bus_a.rom_x, bus_a.rom_y); end
    checks++; if (bus_a.pcm_l !== 24'sd0 || bus_a.pcm_r !== 24'sd0) begin errors++; $display("FAIL reset pcm: got %h/%h want 0/0", bus_a.pcm_l, bus_a.pcm_r); end
    checks++; if (bus_a.overrun !== 1'b0 || bus_b.overrun !== 1'b0) begin errors++; $display("FAIL reset overrun: got %b/%b want 0/0", bus_a.overrun, bus_b.overrun); end
    bad = 0;
    for (int i = 0; i < 1000; i++) begin
      @(negedge clk);
      if (bus_a.busy !== 1'b0 || bus_a.pcm_valid !== 1'b0 || bus_b.busy !== 1'b0 ||
          bus_b.pcm_valid !== 1'b0) bad++;
    end
    checks++; if (bad !== 0) begin errors++; $display("FAIL reset idle 1000 cycles: got %0d active cycles want 0", bad); end
  endtask

  task automatic test_latency();
    int eb, gb;
    reset_a();
    eb = exp_l.size();
    gb = got_l.size();
    for (int i = 0; i < 31; i++) drive_a(i[0], ~i[1]);
    drive_a(1'b1, 1'b0);
    for (int n = 1; n <= 20; n++) begin
      @(negedge clk);
      checks++; if (bus_a.busy !== (n <= 17)) begin errors++; $display("FAIL latency busy T+%0d: got %b want %b", n, bus_a.busy, (n <= 17)); end
      checks++; if (bus_a.pcm_valid !== (n == 17)) begin errors++; $display("FAIL latency pcm_valid T+%0d: got %b want %b", n, bus_a.pcm_valid, (n == 17)); end
      if (n <= 16) begin
        checks++; if (bus_a.rom_addr !== 4'(n - 1)) begin errors++; $display("FAIL latency rom_addr T+%0d: got %0d want %0d", n, bus_a.rom_addr, n - 1); end
      end
      if (n == 3) begin
        checks++; if (bus_a.rom_x !== m_snap_l[29:20] || bus_a.rom_y !== m_snap_r[29:20]) begin errors++; $display("FAIL latency rom_xy addr2: got %h/%h want %h/%h", bus_a.rom_x, bus_a.rom_y, m_snap_l[29:20], m_snap_r[29:20]); end
      end
    end
    checks++; if (got_l.size() - gb !== exp_l.size() - eb) begin errors++; $display("FAIL latency sample count: got %0d want %0d", got_l.size() - gb, exp_l.size() - eb); end
    else begin
      checks++; if (got_l[gb] !== exp_l[eb] || got_r[gb] !== exp_r[eb]) begin errors++; $display("FAIL latency pcm: got %0d/%0d want %0d/%0d", got_l[gb], got_r[gb], exp_l[eb], exp_r[eb]); end
    end
  endtask

  task automatic test_constant();
    int eb, gb;
    reset_a();
    eb = exp_l.size();
    gb = got_l.size();
    for (int i = 0; i < 320; i++) begin
      drive_a(1'b1, 1'b0);
      idle(3);
    end
    for (int w = 0; w < 100 && got_l.size() < gb + 10; w++) @(negedge clk);
    checks++; if (got_l.size() - gb !== 10) begin errors++; $display("FAIL constant sample count: got %0d want 10", got_l.size() - gb); end
    else begin
      for (int i = 4; i < 10; i++) begin
        checks++; if (got_l[gb+i] !== 24'sd100628 || got_r[gb+i] !== -24'sd100629) begin errors++; $display("FAIL constant pcm #%0d: got %0d/%0d want 100628/-100629", i + 1, got_l[gb+i], got_r[gb+i]); end
      end
      for (int i = 0; i < 4; i++) begin
        checks++; if (got_l[gb+i] !== exp_l[eb+i] || got_r[gb+i] !== exp_r[eb+i]) begin errors++; $display("FAIL constant model #%0d: got %0d/%0d want %0d/%0d", i + 1, got_l[gb+i], got_r[gb+i], exp_l[eb+i], exp_r[eb+i]); end
      end
    end
  endtask

  task automatic test_pattern();
    int eb, gb;
    reset_a();
    eb = exp_l.size();
    gb = got_l.size();
    for (int i = 0; i < 192; i++) begin
      drive_a(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
      idle(1);
    end
    for (int w = 0; w < 100 && got_l.size() < gb + 6; w++) @(negedge clk);
    checks++; if (got_l.size() - gb !== 6) begin errors++; $display("FAIL pattern sample count: got %0d want 6", got_l.size() - gb); end
    else begin
      for (int i = 0; i < 6; i++) begin
        checks++; if (got_l[gb+i] !== exp_l[eb+i] || got_r[gb+i] !== exp_r[eb+i]) begin errors++; $display("FAIL pattern pcm #%0d: got %0d/%0d want %0d/%0d", i, got_l[gb+i], got_r[gb+i], exp_l[eb+i], exp_r[eb+i]); end
      end
    end
    checks++; if (bus_a.overrun !== 1'b0) begin errors++; $display("FAIL pattern overrun: got %b want 0", bus_a.overrun); end
  endtask

  task automatic test_abort();
    int eb, gb, pvb;
    bit found;
    reset_a();
    eb = exp_l.size();
    gb = got_l.size();
    for (int i = 0; i < 32; i++) drive_a(1'b1, i[0]);
    for (int w = 0; w < 40 && got_l.size() < gb + 1; w++) @(negedge clk);
    checks++; if (got_l.size() !== gb + 1) begin errors++; $display("FAIL abort first block count: got %0d want 1", got_l.size() - gb); end
    else begin
      checks++; if (got_l[gb] !== exp_l[eb] || got_r[gb] !== exp_r[eb]) begin errors++; $display("FAIL abort first block pcm: got %0d/%0d want %0d/%0d", got_l[gb], got_r[gb], exp_l[eb], exp_r[eb]); end
    end
    for (int i = 0; i < 32; i++) drive_a(1'b0, 1'b1);
    found = 1'b0;
    for (int w = 0; w < 40; w++) begin
      @(negedge clk);
      if (bus_a.busy === 1'b1 && bus_a.rom_addr === 4'd7) begin
        found = 1'b1;
        break;
      end
    end
    checks++; if (found !== 1'b1) begin errors++; $display("FAIL abort reach addr 7: got %b want 1", found); end
    rst_a = 1'b1;
    #1;
    checks++; if (bus_a.busy !== 1'b0 || bus_a.pcm_valid !== 1'b0) begin errors++; $display("FAIL abort busy/valid: got %b/%b want 0/0", bus_a.busy, bus_a.pcm_valid); end
    checks++; if (bus_a.rom_addr !== 4'd0 || bus_a.rom_x !== 10'd0 || bus_a.rom_y !== 10'd0) begin errors++; $display("FAIL abort rom outputs: got %0d/%h/%h want 0/0/0", bus_a.rom_addr, bus_a.rom_x, bus_a.rom_y); end
    checks++; if (bus_a.pcm_l !== 24'sd0 || bus_a.pcm_r !== 24'sd0) begin errors++; $display("FAIL abort pcm: got %0d/%0d want 0/0", bus_a.pcm_l, bus_a.pcm_r); end
    repeat (2) @(posedge clk);
    @(negedge clk) rst_a = 1'b0;
    model_reset_a();
    pvb = pv_a;
    repeat (30) @(negedge clk);
    checks++; if (pv_a !== pvb) begin errors++; $display("FAIL abort stray pcm_valid: got %0d want 0", pv_a - pvb); end
    eb = exp_l.size();
    gb = got_l.size();
    for (int i = 0; i < 32; i++) drive_a(i[1], i[0]);
    for (int w = 0; w < 40 && got_l.size() < gb + 1; w++) @(negedge clk);
    checks++; if (got_l.size() !== gb + 1) begin errors++; $display("FAIL abort next block count: got %0d want 1", got_l.size() - gb); end
    else begin
      checks++; if (got_l[gb] !== exp_l[eb] || got_r[gb] !== exp_r[eb]) begin errors++; $display("FAIL abort next block pcm: got %0d/%0d want %0d/%0d", got_l[gb], got_r[gb], exp_l[eb], exp_r[eb]); end
    end
  endtask

  task automatic test_saturation();
    int base;
    reset_b();
    base = pv_b;
    for (int i = 0; i < 160; i++) begin
      drive_b(1'b1, 1'b0, 1'b0);
      idle(2);
    end
    repeat (25) @(negedge clk);
    checks++; if (pv_b - base !== 20) begin errors++; $display("FAIL saturation ones count: got %0d want 20", pv_b - base); end
    checks++; if (last_b_l !== 24'h7FFFFF || last_b_r !== 24'h800000) begin errors++; $display("FAIL saturation ones pcm: got %h/%h want 7fffff/800000", last_b_l, last_b_r); end
    checks++; if (bus_b.overrun !== 1'b0) begin errors++; $display("FAIL saturation overrun: got %b want 0", bus_b.overrun); end
    base = pv_b;
    for (int i = 0; i < 160; i++) begin
      drive_b(1'b0, 1'b1, 1'b0);
      idle(2);
    end
    repeat (25) @(negedge clk);
    checks++; if (pv_b - base !== 20) begin errors++; $display("FAIL saturation zeros count: got %0d want 20", pv_b - base); end
    checks++; if (last_b_l !== 24'h800000 || last_b_r !== 24'h7FFFFF) begin errors++; $display("FAIL saturation zeros pcm: got %h/%h want 800000/7fffff", last_b_l, last_b_r); end
  endtask

  task automatic test_overrun();
    int base;
    reset_b();
    base = pv_b;
    for (int i = 0; i < 15; i++) drive_b(i[0], 1'b1, 1'b0);
    checks++; if (bus_b.overrun !== 1'b0 || bus_b.busy !== 1'b1) begin errors++; $display("FAIL overrun before 2nd trigger: got ovr=%b busy=%b want 0/1", bus_b.overrun, bus_b.busy); end
    drive_b(1'b0, 1'b0, 1'b0);
    checks++; if (bus_b.overrun !== 1'b1) begin errors++; $display("FAIL overrun at 2nd trigger: got %b want 1", bus_b.overrun); end
    repeat (40) @(negedge clk);
    checks++; if (pv_b - base !== 1) begin errors++; $display("FAIL overrun dropped block count: got %0d want 1", pv_b - base); end
    checks++; if (bus_b.overrun !== 1'b1) begin errors++; $display("FAIL overrun sticky: got %b want 1", bus_b.overrun); end
    bus_b.overrun_clr = 1'b1;
    @(posedge clk);
    #1 bus_b.overrun_clr = 1'b0;
    checks++; if (bus_b.overrun !== 1'b0) begin errors++; $display("FAIL overrun clear: got %b want 0", bus_b.overrun); end
    for (int i = 0; i < 15; i++) drive_b(1'b1, i[0], 1'b0);
    drive_b(1'b1, 1'b1, 1'b1);
    checks++; if (bus_b.overrun !== 1'b1) begin errors++; $display("FAIL overrun set beats clear: got %b want 1", bus_b.overrun); end
    bus_b.overrun_clr = 1'b1;
    @(posedge clk);
    #1 bus_b.overrun_clr = 1'b0;
    checks++; if (bus_b.overrun !== 1'b0) begin errors++; $display("FAIL overrun second clear: got %b want 0", bus_b.overrun); end
    repeat (40) @(negedge clk);
    checks++; if (pv_b - base !== 2) begin errors++; $display("FAIL overrun wrap block count: got %0d want 2", pv_b - base); end
  endtask

  initial begin
    rst_a = 1'b1;
    rst_b = 1'b1;
    model_reset_a();
    test_reset();
    test_latency();
    test_constant();
    test_pattern();
    test_abort();
    test_saturation();
    test_overrun();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
